// File: rtl/sha256_w_sched.sv
// sha256_w_sched: SHA-256 message schedule generator (initiator side of the sig0/sig1 CFUs).
// Loads a 16-word message block (passed straight through to the output), then expands
// W[16..NUM_WORDS-1] using external combinational sig0/sig1 responders.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_data    message word input stream (W[0..15])
//   out_valid/out_ready/out_data schedule word output stream
//   out_idx, out_last            index of out_data, high on the final word
//   flush                        abandon current block and return to LOAD
//   sig0_op/sig0_res             sig0 responder operand (W[t-15]) and result
//   sig1_op/sig1_res             sig1 responder operand (W[t-2]) and result
module sha256_w_sched #(
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  output logic        out_last,
  input  logic        flush,
  output logic [31:0] sig0_op,
  input  logic [31:0] sig0_res,
  output logic [31:0] sig1_op,
  input  logic [31:0] sig1_res
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned WIN    = 16;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] LOAD_LAST = IDX_W'(WIN - 1);

  typedef enum logic {
    S_LOAD,
    S_EXPAND
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  t_q;
  // shreg_q[i] = W[t-16+i]; index 15 holds the newest word
  logic [WORD_W-1:0] shreg_q [WIN];

  logic [WORD_W-1:0] expand_d;
  logic              accept;

  // Responder operands come straight from the window in every state
  assign sig0_op = shreg_q[1];
  assign sig1_op = shreg_q[14];

  // Output/handshake decode; LOAD is a zero-bubble pass-through
  always_comb begin
    expand_d  = sig1_res + shreg_q[9] + sig0_res + shreg_q[0];
    in_ready  = 1'b0;
    out_valid = 1'b1;
    out_data  = expand_d;
    if (state_q == S_LOAD) begin
      in_ready  = out_ready;
      out_valid = in_valid;
      out_data  = in_data;
    end
    accept   = out_valid & out_ready;
    out_idx  = t_q;
    out_last = out_valid & (t_q == LAST_IDX);
  end

  // State, index and window update; rst beats flush, flush discards the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      t_q     <= '0;
      for (int i = 0; i < int'(WIN); i++) shreg_q[i] <= '0;
    end else if (flush) begin
      state_q <= S_LOAD;
      t_q     <= '0;
    end else if (accept) begin
      for (int i = 0; i < int'(WIN) - 1; i++) shreg_q[i] <= shreg_q[i+1];
      shreg_q[WIN-1] <= out_data;
      case (state_q)
        S_LOAD: begin
          if (t_q == LOAD_LAST) state_q <= S_EXPAND;
          t_q <= t_q + IDX_W'(1);
        end
        default: begin
          if (t_q == LAST_IDX) begin
            state_q <= S_LOAD;
            t_q     <= '0;
          end else begin
            t_q <= t_q + IDX_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_w_sched.sv
module tb_sha256_w_sched;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush;
  logic [31:0] in_data;

  logic        ir_a, ov_a, ol_a, ir_b, ov_b, ol_b;
  logic [31:0] od_a, s0o_a, s0r_a, s1o_a, s1r_a;
  logic [31:0] od_b, s0o_b, s0r_b, s1o_b, s1r_b;
  logic [5:0]  oi_a, oi_b;

  logic        sel;
  logic        ir, ov, ol;
  logic [31:0] od, s0o, s1o;
  logic [5:0]  oi;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cur_blk[16];
  logic [31:0] got_w[64];
  int          last_cyc;

  always #5 clk = ~clk;

  function automatic logic [31:0] f_sig0(logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_sig1(logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Combinational responders
  assign s0r_a = f_sig0(s0o_a);
  assign s1r_a = f_sig1(s1o_a);
  assign s0r_b = f_sig0(s0o_b);
  assign s1r_b = f_sig1(s1o_b);

  sha256_w_sched #(.NUM_WORDS(64)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_idx(oi_a),
    .out_last(ol_a), .flush(flush), .sig0_op(s0o_a), .sig0_res(s0r_a),
    .sig1_op(s1o_a), .sig1_res(s1r_a));

  sha256_w_sched #(.NUM_WORDS(17)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_idx(oi_b),
    .out_last(ol_b), .flush(flush), .sig0_op(s0o_b), .sig0_res(s0r_b),
    .sig1_op(s1o_b), .sig1_res(s1r_b));

  always_comb begin
    ir  = sel ? ir_b  : ir_a;
    ov  = sel ? ov_b  : ov_a;
    ol  = sel ? ol_b  : ol_a;
    od  = sel ? od_b  : od_a;
    oi  = sel ? oi_b  : oi_a;
    s0o = sel ? s0o_b : s0o_a;
    s1o = sel ? s1o_b : s1o_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
  endtask

  // Run one block. mode: 0 continuous, 1 random out_ready, 2 in_valid gaps.
  // action: 0 none, 1 flush, 2 rst, applied when word stop_at is presented.
  task automatic run_block(input int nw, input int mode, input int stop_at, input int action);
    logic [31:0] w[64];
    logic [31:0] e, prev_data;
    logic        prev_stall, gap;
    int          li, got, cyc;
    for (int t = 0; t < 16; t++) w[t] = cur_blk[t];
    for (int t = 16; t < 64; t++)
      w[t] = f_sig1(w[t-2]) + w[t-7] + f_sig0(w[t-15]) + w[t-16];
    exp_q.delete();
    for (int t = 0; t < nw; t++) exp_q.push_back(w[t]);
    li = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    while (got < nw && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      gap       = (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      in_valid  = (li < 16) && !gap;
      in_data   = in_valid ? cur_blk[li] : $urandom;
      #1;
      if (prev_stall) chk("stall_hold", od, prev_data);
      if (got < 16) chk("load_valid", 32'(ov), 32'(in_valid));
      if (action != 0 && got == stop_at && ov) begin
        if (action == 1) flush = 1'b1; else rst = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("abort_valid", 32'(ov), 32'h0);
        chk("abort_idx", 32'(oi), 32'h0);
        chk("abort_ready", 32'(ir), 32'(out_ready));
        if (action == 2) begin
          chk("rst_sig0op", s0o, 32'h0);
          chk("rst_sig1op", s1o, 32'h0);
        end
        exp_q.delete();
        return;
      end
      if (ov && out_ready) begin
        e = exp_q.pop_front();
        got_w[got] = od;
        chk($sformatf("data_w%0d", got), od, e);
        chk($sformatf("idx_w%0d", got), 32'(oi), 32'(got));
        chk($sformatf("last_w%0d", got), 32'(ol), 32'(got == nw - 1));
        if (got < 16) li++;
        got++;
      end
      prev_stall = ov && !out_ready && got >= 16;
      prev_data  = od;
    end
    last_cyc = cyc;
    chk("block_done", 32'(got), 32'(nw));
    // Block complete: back in LOAD, idle with no input
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_valid", 32'(ov), 32'h0);
    chk("post_idx", 32'(oi), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = 32'h1234_5678;
    do_reset();
    in_data = 32'h1234_5678;
    #1;
    chk("rst_valid", 32'(ov), 32'h0);
    chk("rst_idx", 32'(oi), 32'h0);
    chk("rst_last", 32'(ol), 32'h0);
    chk("rst_ready", 32'(ir), 32'h1);
    chk("rst_passthru", od, 32'h1234_5678);
    chk("rst_sig0op", s0o, 32'h0);
    chk("rst_sig1op", s1o, 32'h0);

    // "abc" block, continuous
    for (int i = 0; i < 16; i++) cur_blk[i] = '0;
    cur_blk[0]  = 32'h6162_6380;
    cur_blk[15] = 32'h0000_0018;
    run_block(64, 0, 0, 0);
    chk("abc_w16", got_w[16], 32'h6162_6380);
    chk("abc_w17", got_w[17], 32'h000F_0000);
    chk("abc_cycles", 32'(last_cyc), 32'd64);

    // "abc" block with random backpressure
    run_block(64, 1, 0, 0);
    chk("abc_bp_w16", got_w[16], 32'h6162_6380);
    chk("abc_bp_w17", got_w[17], 32'h000F_0000);

    // in_valid gaps during LOAD
    rand_block();
    run_block(64, 2, 0, 0);

    // flush at t=30 then a fresh block
    rand_block();
    run_block(64, 0, 30, 1);
    rand_block();
    run_block(64, 1, 0, 0);

    // reset mid-load and mid-expand, each followed by a full block
    rand_block();
    run_block(64, 0, 5, 2);
    rand_block();
    run_block(64, 0, 0, 0);
    rand_block();
    run_block(64, 0, 40, 2);
    rand_block();
    run_block(64, 1, 0, 0);

    // NUM_WORDS=17 instance
    sel = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      rand_block();
      run_block(17, (k == 0) ? 0 : 1, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
